// File: rtl/switch_ctrl_seq.sv
// ---------------------------------------------------------------------------
// switch_ctrl_seq
// Control-side sequencer for a column of NUM_SW registered 2x2 switch
// elements. Holds DEPTH swap patterns and replays a programmed run of them,
// one pattern per accepted data beat, then flags when the switched data
// emerges at the column outputs LAT cycles after each beat.
//
// Ports
//   clk         clock
//   rst         asynchronous reset, active-high
//   cfg_we      pattern write strobe (honoured only while idle)
//   cfg_addr    pattern entry to write
//   cfg_data    pattern: bit k = 1 -> switch k swaps its ports
//   start       single-cycle run request (honoured only while idle)
//   pat_base    first pattern entry of the run (sampled with start)
//   pat_len     number of beats in the run, 0..DEPTH (sampled with start)
//   beat_valid  data beat presented to the switch inputs this cycle
//   sw_set      switch_set bus, one bit per switch element
//   out_valid   switched data valid at the column outputs this cycle
//   busy        run in progress
//   done        one-cycle pulse: run complete
//   cfg_err     one-cycle pulse: pattern write rejected because busy
// ---------------------------------------------------------------------------
module switch_ctrl_seq #(
  parameter int NUM_SW = 8,
  parameter int DEPTH  = 16,
  parameter int LAT    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [NUM_SW-1:0]          cfg_data,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   pat_base,
  input  logic [$clog2(DEPTH):0]     pat_len,
  input  logic                       beat_valid,
  output logic [NUM_SW-1:0]          sw_set,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int AW = $clog2(DEPTH);

  // Only the oldest beat left in the latency pipe: the run's final beat is
  // leaving the column this cycle.
  localparam logic [LAT-1:0] LAST_ONLY = LAT'(1) << (LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_SW-1:0] pat_mem [DEPTH];
  logic [AW-1:0]     ptr_q;
  logic [AW:0]       rem_q;
  logic [LAT-1:0]    vpipe_q;
  logic [NUM_SW-1:0] sw_q;
  logic              done_zero_q;
  logic              cfg_err_q;

  logic              idle;
  logic              accept;
  logic              last_out;

  assign idle     = (state_q == S_IDLE);
  assign last_out = (vpipe_q == LAST_ONLY);

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (pat_len != '0)) state_d = S_RUN;
      end
      S_RUN: begin
        if (beat_valid) begin
          accept = 1'b1;
          if (rem_q == (AW+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_out) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      vpipe_q     <= '0;
      sw_q        <= '0;
      done_zero_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vpipe_q     <= {vpipe_q[LAT-2:0], accept};
      done_zero_q <= idle && start && (pat_len == '0);
      cfg_err_q   <= cfg_we && !idle;
      if (idle && start) begin
        ptr_q <= pat_base;
        rem_q <= pat_len;
      end else if (accept) begin
        // Pattern lands the cycle the switch element samples switch_set.
        sw_q  <= pat_mem[ptr_q];
        ptr_q <= ptr_q + AW'(1);  // DEPTH is a power of 2: wraps naturally
        rem_q <= rem_q - (AW+1)'(1);
      end
    end
  end

  // NOTE: the pattern file has no reset; software programs it before use,
  // and leaving it unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (cfg_we && idle) pat_mem[cfg_addr] <= cfg_data;
  end

  assign sw_set    = sw_q;
  assign out_valid = vpipe_q[LAT-1];
  assign busy      = !idle;
  assign done      = done_zero_q || ((state_q == S_DRAIN) && last_out);
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_switch_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_switch_ctrl_seq
// Self-checking bench for switch_ctrl_seq. A run is described as a list of
// accepted-beat cycles; expected sw_set / out_valid / busy / done / cfg_err
// for every cycle are derived from that list and a shadow pattern table.
// ---------------------------------------------------------------------------
module tb_switch_ctrl_seq;

  localparam int NUM_SW = 8;
  localparam int DEPTH  = 16;
  localparam int LAT    = 3;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [NUM_SW-1:0] cfg_data;
  logic              start;
  logic [AW-1:0]     pat_base;
  logic [AW:0]       pat_len;
  logic              beat_valid;
  logic [NUM_SW-1:0] sw_set;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              cfg_err;

  always #5 clk = ~clk;

  switch_ctrl_seq #(.NUM_SW(NUM_SW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start      (start),
    .pat_base   (pat_base),
    .pat_len    (pat_len),
    .beat_valid (beat_valid),
    .sw_set     (sw_set),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  int checks = 0;
  int errors = 0;

  logic [NUM_SW-1:0] ref_mem [DEPTH];
  logic [NUM_SW-1:0] last_sw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    start      = 1'b0;
    pat_base   = '0;
    pat_len    = '0;
    beat_valid = 1'b0;
  endtask

  task automatic write_cfg(input int addr, input logic [NUM_SW-1:0] data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = data;
    ref_mem[addr] = data;
    @(negedge clk);
    check($sformatf("cfg_err idle write %0d", addr), 32'(cfg_err), 32'(0));
    drive_idle();
  endtask

  // One complete run. Cycle 0 carries start; the run can accept beats from
  // cycle 1. Beat pattern comes from mask (cycle i uses mask[i-1]) or from a
  // random density; noise adds ignored starts / writes while busy.
  task automatic run(input string name, input int base, input int len,
                     input int density, input bit use_mask, input logic [31:0] mask,
                     input bit noise, input bit wr_same);
    bit   bv [128];
    int   acc [$];
    int   done_i, n, k;
    logic exp_ov, exp_busy, exp_err, prev_we, prev_busy;
    logic [NUM_SW-1:0] exp_sw, wd;

    if (wr_same) begin
      wd = NUM_SW'($urandom);
      ref_mem[base] = wd;  // write and start in the same idle cycle
    end else begin
      wd = '0;
    end

    acc = {};
    for (int i = 1; i < 128; i++) begin
      if (use_mask) bv[i] = (i <= 32) ? mask[i-1] : 1'b1;
      else          bv[i] = (i > 40) ? 1'b1 : ($urandom_range(99) < density);
      if (bv[i] && acc.size() < len) acc.push_back(i);
    end
    done_i = (len == 0) ? 1 : acc[len-1] + LAT;
    n      = done_i + 3;

    prev_we   = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      k = 0;
      exp_ov = 1'b0;
      foreach (acc[j]) begin
        if (acc[j] + 1 <= i) k++;
        if (acc[j] + LAT == i) exp_ov = 1'b1;
      end
      exp_sw   = (k == 0) ? last_sw : ref_mem[(base + k - 1) % DEPTH];
      exp_busy = (len > 0) && (i >= 1) && (i <= done_i);
      exp_err  = prev_we && prev_busy;
      check($sformatf("%s sw_set c%0d", name, i),    32'(sw_set),    32'(exp_sw));
      check($sformatf("%s out_valid c%0d", name, i), 32'(out_valid), 32'(exp_ov));
      check($sformatf("%s busy c%0d", name, i),      32'(busy),      32'(exp_busy));
      check($sformatf("%s done c%0d", name, i),      32'(done),      32'(i == done_i));
      check($sformatf("%s cfg_err c%0d", name, i),   32'(cfg_err),   32'(exp_err));

      if (i == 0) begin
        start      = 1'b1;
        pat_base   = AW'(base);
        pat_len    = (AW+1)'(len);
        beat_valid = noise ? 1'($urandom) : 1'b0;
        cfg_we     = wr_same;
        cfg_addr   = AW'(base);
        cfg_data   = wd;
      end else begin
        start      = noise && exp_busy && ($urandom_range(3) == 0);
        pat_base   = AW'($urandom);
        pat_len    = (AW+1)'($urandom_range(DEPTH));
        beat_valid = (i < n) ? bv[i] : 1'b0;
        cfg_we     = noise && exp_busy && ($urandom_range(2) == 0);
        cfg_addr   = AW'($urandom);
        cfg_data   = NUM_SW'($urandom);
      end
      prev_we   = cfg_we;
      prev_busy = exp_busy;
    end
    if (len > 0) last_sw = ref_mem[(base + len - 1) % DEPTH];
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst     = 1'b1;
    last_sw = '0;
    #1;
    check("reset sw_set",    32'(sw_set),    32'(0));
    check("reset out_valid", 32'(out_valid), 32'(0));
    check("reset busy",      32'(busy),      32'(0));
    check("reset done",      32'(done),      32'(0));
    check("reset cfg_err",   32'(cfg_err),   32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < DEPTH; a++) write_cfg(a, NUM_SW'($urandom));

    // Basic run, one beat per cycle.
    write_cfg(0, 8'h01);
    write_cfg(1, 8'h02);
    write_cfg(2, 8'h04);
    write_cfg(3, 8'h08);
    run("basic", 0, 4, 100, 1'b1, 32'h0000_000F, 1'b0, 1'b0);

    // Pointer wrap DEPTH-1 -> 0.
    write_cfg(14, 8'hA5);
    write_cfg(15, 8'h5A);
    write_cfg(0,  8'hFF);
    write_cfg(1,  8'h00);
    run("wrap", 14, 4, 100, 1'b1, 32'h0000_000F, 1'b0, 1'b0);

    // Stalls: beat_valid 1,0,0,1,1.
    run("stall", 6, 3, 0, 1'b1, 32'h0000_0019, 1'b0, 1'b0);

    // Zero-length run.
    run("len0", 5, 0, 50, 1'b0, 32'h0, 1'b0, 1'b0);

    // Writes and starts while busy are ignored; re-run sees old patterns.
    run("busy_noise", 2, 6, 60, 1'b0, 32'h0, 1'b1, 1'b0);
    run("rerun", 2, 6, 100, 1'b0, 32'h0, 1'b0, 1'b0);

    // Write and start in the same idle cycle.
    run("wr_start", 11, 3, 70, 1'b0, 32'h0, 1'b0, 1'b1);

    // Full-depth run crossing the wrap.
    run("full", 9, DEPTH, 80, 1'b0, 32'h0, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run($sformatf("rand%0d", r), $urandom_range(DEPTH-1), $urandom_range(DEPTH),
          $urandom_range(90, 30), 1'b0, 32'h0, 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a run.
    @(negedge clk);
    start    = 1'b1;
    pat_base = '0;
    pat_len  = (AW+1)'(8);
    @(negedge clk);
    start      = 1'b0;
    beat_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("midrun busy before reset", 32'(busy), 32'(1));
    rst        = 1'b1;
    beat_valid = 1'b0;
    #1;
    check("midrun reset sw_set",    32'(sw_set),    32'(0));
    check("midrun reset out_valid", 32'(out_valid), 32'(0));
    check("midrun reset busy",      32'(busy),      32'(0));
    check("midrun reset done",      32'(done),      32'(0));
    check("midrun reset cfg_err",   32'(cfg_err),   32'(0));
    @(negedge clk);
    rst     = 1'b0;
    last_sw = '0;
    run("after_reset", 4, 5, 75, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
